// File: rtl/pipelined_hybrid_adder.sv
// Pipelined adder/subtractor built from chained block carry-lookahead units.
// There is one register stage per group of BPS blocks, with valid/ready flow control at both ends.
module pipelined_hybrid_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4,
  parameter int BPS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int C      = BLK * BPS;
  localparam int STAGES = WIDTH / C;
  localparam int LAST   = STAGES - 1;

  // Each carry is a flat product-of-generate/propagate term, so there is no ripple inside a block.
  // The result is packed as {carry out, carry into MSB, sum}.
  function automatic logic [BLK+1:0] bcla(input logic [BLK-1:0] x,
                                          input logic [BLK-1:0] y,
                                          input logic           ci);
    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    logic [BLK-1:0] s;
    logic [BLK:0]   c;
    logic           term;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLK; i++) begin
      term = ci;
      for (int k = 0; k <= i; k++) term = term & p[k];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
    s = p ^ c[BLK-1:0];
    return {c[BLK], c[BLK-1], s};
  endfunction

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_c;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic              r_ovf;
  logic              r_zero;

  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_c;
  logic [WIDTH-1:0]  w_a   [STAGES];
  logic [WIDTH-1:0]  w_b   [STAGES];
  logic [WIDTH-1:0]  w_sum [STAGES];
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_c_eff;
  logic              w_ovf;
  logic              w_zero;

  assign w_b_eff = b ^ {WIDTH{sub}};
  assign w_c_eff = sub | cin;

  // Walk from the output back to the input.
  // A stage has room when it is empty or its own contents are leaving this cycle.
  always_comb begin : p_handshake
    logic room;
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    w_adv  = '0;
    w_load = '0;
    room   = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      w_adv[k] = r_valid[k] && room;
      room     = !r_valid[k] || room;
      if (k < LAST) w_load[k+1] = w_adv[k];
    end
    in_ready  = room;
    w_load[0] = in_valid && room;
  end

  always_comb begin : p_datapath
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ss;
    logic [BLK+1:0]   res;
    logic             carry;
    logic             cmsb;
    w_c    = '0;
    w_ovf  = 1'b0;
    w_zero = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        sa    = a;
        sb    = w_b_eff;
        carry = w_c_eff;
        ss    = '0;
      end else begin
        sa    = r_a[k-1];
        sb    = r_b[k-1];
        carry = r_c[k-1];
        ss    = r_sum[k-1];
      end
      cmsb = 1'b0;
      for (int j = 0; j < BPS; j++) begin
        res = bcla(sa[k*C + j*BLK +: BLK], sb[k*C + j*BLK +: BLK], carry);
        ss[k*C + j*BLK +: BLK] = res[BLK-1:0];
        cmsb  = res[BLK];
        carry = res[BLK+1];
      end
      w_a[k]   = sa;
      w_b[k]   = sb;
      w_sum[k] = ss;
      w_c[k]   = carry;
      // Only the final chunk holds the word MSB, so only it produces the signed-overflow flag.
      if (k == LAST) begin
        w_ovf  = carry ^ cmsb;
        w_zero = (ss == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand/sum arrays are small stage registers, not a RAM.
      // Clearing them makes the outputs read 0 after reset.
      r_valid <= '0;
      r_c     <= '0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_load[k] | (r_valid[k] & ~w_adv[k]);
        if (w_load[k]) begin
          r_a[k]   <= w_a[k];
          r_b[k]   <= w_b[k];
          r_sum[k] <= w_sum[k];
          r_c[k]   <= w_c[k];
        end
      end
      if (w_load[LAST]) begin
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end
    end
  end

  assign out_valid = r_valid[LAST];
  assign sum       = r_sum[LAST];
  assign cout      = r_c[LAST];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_hybrid_adder.sv
// Scoreboard bench for pipelined_hybrid_adder (WIDTH=16, BLK=4, BPS=1).
// Expected results are queued at accept and retired in order.
module tb_pipelined_hybrid_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int   n_vec;
  int   n_err;
  res_t exp_q[$];

  pipelined_hybrid_adder #(.WIDTH(16), .BLK(4), .BPS(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer add, with overflow taken from operand/result sign bits.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic s);
    logic [15:0] be;
    logic [16:0] full;
    res_t        r;
    be     = s ? ~y : y;
    full   = {1'b0, x} + {1'b0, be} + {16'd0, (s ? 1'b1 : ci)};
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ovf  = (x[15] == be[15]) && (r.sum[15] != x[15]);
    r.zero = (r.sum == 16'd0);
    return r;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("sum=%h cout=%b ovf=%b zero=%b", r.sum, r.cout, r.ovf, r.zero);
  endfunction

  // One clock: settle inputs, note accept/retire, push the expected value on accept.
  task automatic cycle(output logic acc, output logic ret, output logic vld, output res_t got);
    #1;
    acc      = in_valid && in_ready && !rst;
    ret      = out_valid && out_ready && !rst;
    vld      = out_valid;
    got.sum  = sum;
    got.cout = cout;
    got.ovf  = ovf;
    got.zero = zero;
    if (acc) exp_q.push_back(model(a, b, cin, sub));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic acc, ret, vld;
    res_t got;
    rst = 1'b1;
    @(negedge clk);
    repeat (2) cycle(acc, ret, vld, got);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, sum, cout, ovf, zero} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got out_valid=%b sum=%h cout=%b ovf=%b zero=%b, want all 0",
               out_valid, sum, cout, ovf, zero);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_carry_chain();
    logic acc, ret, vld;
    res_t got, exp;
    int   lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
    cycle(acc, ret, vld, got);
    n_vec++;
    if (acc !== 1'b1) begin
      n_err++;
      $display("FAIL chain_accept: got %b, want 1", acc);
    end
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      cycle(acc, ret, vld, got);
      lat++;
    end
    n_vec++;
    if (lat != 4) begin
      n_err++;
      $display("FAIL chain_latency: got %0d cycles, want 4", lat);
    end
    cycle(acc, ret, vld, got);
    n_vec++;
    if (!ret || exp_q.size() == 0) begin
      n_err++;
      $display("FAIL chain_retire: got ret=%b queued=%0d, want a queued result", ret, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_err++;
        $display("FAIL chain_model: got %s, want %s", fmt(got), fmt(exp));
      end
      n_vec++;
      if (got !== res_t'{16'h0000, 1'b1, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL chain_const: got %s, want sum=0000 cout=1 ovf=0 zero=1", fmt(got));
      end
    end
  endtask

  task automatic test_directed();
    logic        acc, ret, vld;
    res_t        got, exp;
    logic [15:0] ta [4] = '{16'h7FFF, 16'h0005, 16'h8000, 16'hFFFF};
    logic [15:0] tb [4] = '{16'h0001, 16'h0007, 16'h0001, 16'hFFFF};
    logic        tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        ts [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    res_t        tr [4] = '{'{16'h8000, 1'b0, 1'b1, 1'b0},
                            '{16'hFFFE, 1'b0, 1'b0, 1'b0},
                            '{16'h7FFF, 1'b1, 1'b1, 1'b0},
                            '{16'hFFFF, 1'b1, 1'b0, 1'b0}};
    int          issued, retired;
    issued = 0; retired = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && retired < 4; c++) begin
      if (issued < 4) begin
        in_valid = 1'b1;
        a = ta[issued]; b = tb[issued]; cin = tc[issued]; sub = ts[issued];
      end else begin
        in_valid = 1'b0;
      end
      cycle(acc, ret, vld, got);
      if (acc) issued++;
      if (ret) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL dir_extra: unexpected result %s", fmt(got));
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL dir_model[%0d]: got %s, want %s", retired, fmt(got), fmt(exp));
          end
        end
        n_vec++;
        if (got !== tr[retired]) begin
          n_err++;
          $display("FAIL dir_const[%0d]: got %s, want %s", retired, fmt(got), fmt(tr[retired]));
        end
        retired++;
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (retired != 4) begin
      n_err++;
      $display("FAIL dir_count: got %0d results, want 4", retired);
    end
  endtask

  task automatic test_backpressure();
    logic acc, ret, vld;
    res_t got, exp, held;
    logic held_ok;
    int   issued, retired, stall_acc;
    issued = 0; retired = 0; stall_acc = 0; held_ok = 1'b0; held = '0;
    for (int c = 0; c < 60 && retired < 6; c++) begin
      out_ready = (c >= 6);
      if (issued < 6) begin
        in_valid = 1'b1;
        a   = 16'(issued + 1);
        b   = 16'(16'h1000 * (issued + 1));
        cin = 1'b0; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      cycle(acc, ret, vld, got);
      if (acc) begin
        issued++;
        if (c < 6) stall_acc++;
      end
      if (vld && !out_ready) begin
        if (held_ok) begin
          n_vec++;
          if (got !== held) begin
            n_err++;
            $display("FAIL bp_hold: got %s, want %s", fmt(got), fmt(held));
          end
        end
        held    = got;
        held_ok = 1'b1;
      end else begin
        held_ok = 1'b0;
      end
      if (ret) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL bp_extra: unexpected result %s", fmt(got));
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL bp_model[%0d]: got %s, want %s", retired, fmt(got), fmt(exp));
          end
        end
        n_vec++;
        if (got.sum !== 16'(16'h1001 * (retired + 1))) begin
          n_err++;
          $display("FAIL bp_order[%0d]: got sum=%h, want %h", retired, got.sum,
                   16'(16'h1001 * (retired + 1)));
        end
        retired++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_vec++;
    if (stall_acc != 4) begin
      n_err++;
      $display("FAIL bp_fill: got %0d accepts while stalled, want 4", stall_acc);
    end
    n_vec++;
    if (retired != 6) begin
      n_err++;
      $display("FAIL bp_count: got %0d results, want 6", retired);
    end
  endtask

  task automatic test_throughput();
    logic acc, ret, vld;
    res_t got, exp;
    int   issued, retired, first, last;
    issued = 0; retired = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 80 && retired < 20; c++) begin
      if (issued < 20) begin
        in_valid = 1'b1;
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      cycle(acc, ret, vld, got);
      if (acc) issued++;
      if (ret) begin
        if (first < 0) first = c;
        last = c;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL tp_extra: unexpected result %s", fmt(got));
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL tp_model[%0d]: got %s, want %s", retired, fmt(got), fmt(exp));
          end
        end
        retired++;
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (first != 4 || last != 23 || retired != 20) begin
      n_err++;
      $display("FAIL tp_rate: got first=%0d last=%0d count=%0d, want 4 23 20", first, last, retired);
    end
  endtask

  task automatic test_mid_reset();
    logic acc, ret, vld;
    res_t got, exp;
    int   stale, waited;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 16'(16'h0100 * (i + 1)); b = 16'h0011; cin = 1'b1; sub = 1'b0;
      cycle(acc, ret, vld, got);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cycle(acc, ret, vld, got);
    rst = 1'b0;
    exp_q.delete();
    #1;
    n_vec++;
    if ({out_valid, sum, cout, ovf, zero} !== 20'd0) begin
      n_err++;
      $display("FAIL mr_outputs: got out_valid=%b sum=%h cout=%b ovf=%b zero=%b, want all 0",
               out_valid, sum, cout, ovf, zero);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mr_in_ready: got %b, want 1", in_ready);
    end
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(acc, ret, vld, got);
      if (vld) stale++;
    end
    n_vec++;
    if (stale != 0) begin
      n_err++;
      $display("FAIL mr_stale: got %0d cycles with out_valid, want 0", stale);
    end
    in_valid = 1'b1;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0;
    cycle(acc, ret, vld, got);
    in_valid = 1'b0;
    waited = 0;
    ret = 1'b0;
    while (!ret && waited < 10) begin
      cycle(acc, ret, vld, got);
      waited++;
    end
    n_vec++;
    if (!ret || exp_q.size() != 1) begin
      n_err++;
      $display("FAIL mr_after: got ret=%b queued=%0d, want one result", ret, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp || got.sum !== 16'h5555) begin
        n_err++;
        $display("FAIL mr_after_value: got %s, want %s", fmt(got), fmt(exp));
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    test_reset();
    test_carry_chain();
    test_directed();
    test_backpressure();
    test_throughput();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_hybrid_adder.md
# pipelined_hybrid_adder

Parametrised, pipelined adder/subtractor built from chained block carry-lookahead (BCLA) units, with a register stage after every group of blocks. It is the scalable successor to the 8-bit two-block hybrid adder. It is intended as the shared arithmetic core for the ALU and datapath assignments. Operands enter and results leave through valid/ready handshakes with full backpressure; throughput is one operation per cycle.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of BLK*BPS.
- BLK, 4: bits per BCLA block. Each block has internal 4-style lookahead: ripple-free carries computed from per-bit p/g.
- BPS, 1: BCLA blocks per pipeline stage. STAGES = WIDTH/(BLK*BPS).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB. For subtraction, 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

## Operation
- An accept occurs when in_valid && in_ready. The beat is captured into stage 0.
- Effective B is b XOR {WIDTH{sub}}. Effective carry-in is sub ? 1 : cin.
- Stage k (0..STAGES-1) adds chunk k, bits [k*C +: C] with C = BLK*BPS, using BPS chained BCLA blocks.
  - Carry-in for stage k is the registered carry from stage k-1. Stage 0 uses the effective carry-in.
- Each stage register holds:
  - a valid bit;
  - completed low sum chunks;
  - the unprocessed upper operand chunks;
  - the running carry;
  - the carry into the current chunk's MSB (needed by the last stage for ovf).
- The last stage register drives sum, cout, ovf and zero directly. zero is computed on the full sum before it is registered.
- Stage k advances when it is valid and stage k+1 is empty or advancing. The last stage advances when out_ready is high.
- in_ready = !stage0_valid || stage0_advances. This is combinational from out_ready through the chain, so a full pipeline accepts a new beat in the same cycle a result retires.
- Results retire in accept order; no beat is dropped or duplicated.
- While out_valid && !out_ready, sum/cout/ovf/zero hold stable.
- Reset:
  - all valid bits clear;
  - sum, cout, ovf and zero are 0;
  - out_valid is 0;
  - in_ready is 1 in the first cycle after reset deasserts.
- A reset asserted mid-operation discards every in-flight beat. No result for those beats is ever presented.
- Arithmetic is modulo 2^WIDTH; the carry beyond the MSB is reported only in cout.

## Timing
- Latency is STAGES cycles: a beat accepted at edge N gives out_valid high after edge N+STAGES-1, with out_ready held high throughout. Example: WIDTH=16, BLK=4, BPS=1 gives 4 cycles.
- Throughput is 1 beat/cycle with out_ready continuously high.
- Under stall, the pipeline holds up to STAGES beats. in_ready falls only when all stages are valid and out_ready=0.
- Combinational critical path per stage is BPS BCLA blocks, with a ripple between blocks.
- No path from in_valid to in_ready.

## Test plan
All cases use WIDTH=16, BLK=4, BPS=1.
- Carry chain through all stages:
  - Stimulus: a=0xFFFF, b=0x0001, cin=0, sub=0.
  - Response: sum=0x0000, cout=1, ovf=0, zero=1; out_valid exactly 4 cycles after accept.
- Signed overflow on add:
  - Stimulus: a=0x7FFF, b=0x0001, add.
  - Response: sum=0x8000, cout=0, ovf=1, zero=0.
- Subtract with borrow, and cin ignored:
  - Stimulus: a=0x0005, b=0x0007, sub=1, cin=0.
  - Response: sum=0xFFFE, cout=0, ovf=0.
  - Stimulus: a=0x8000, b=0x0001, sub=1, cin=1.
  - Response: sum=0x7FFF, cout=1, ovf=1.
- Backpressure:
  - Stimulus: 6 back-to-back beats (a=i, b=0x1000*i, i=1..6) with out_ready=0 for the first 6 cycles, then out_ready=1.
  - Response: in_ready drops after 4 accepts; results emerge in order 0x1001, 0x2002, …, 0x6006; each held stable while stalled.
- Full-rate throughput:
  - Stimulus: 20 random beats, in_valid and out_ready always 1.
  - Response: one result per cycle after the 4-cycle fill, each matching a reference model (sum, cout, ovf, zero).
- Reset mid-flight:
  - Stimulus: 3 beats in flight, then rst=1 for one cycle.
  - Response: the next cycle has out_valid=0, all outputs 0 and in_ready=1; no stale result appears afterwards.
